// File: rtl/effect_pkg.sv
// effect_pkg: shared FSM state type and gain/multiplier constants for the tremolo stage
package effect_pkg;
    typedef enum logic [1:0] {S_IDLE, S_GAIN, S_MUL, S_DONE} state_t;
    localparam int GAIN_ONE  = 65535;
    localparam int GAIN_HALF = 32768;
    localparam int LFO_SHIFT = 15;
    localparam int MUL_ITERS = 16;
endpackage

// File: rtl/seq_mul_su16.sv
// seq_mul_su16: 16-iteration shift-add signed(a) x unsigned(b) multiplier
// ports: clk, rst_n (async low), start loads a/b, done marks the final iteration cycle,
// product is the full 32-bit result and is valid while done is high
module seq_mul_su16
    import effect_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic signed [15:0] a,
    input  logic        [15:0] b,
    output logic               done,
    output logic signed [31:0] product
);
    logic busy;
    logic [3:0] cnt;
    logic signed [31:0] acc, mcand;
    logic [15:0] mplier;
    // product is the accumulator after the current bit, so the last sum is usable the cycle done is high
    assign product = acc + (mplier[0] ? mcand : 32'sd0);
    assign done = busy && cnt == 4'(MUL_ITERS - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{16{a[15]}}, a};
            mplier <= b;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand <<< 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 4'd1;
            busy   <= !done;
        end
    end
endmodule

// File: rtl/tremolo_modulator.sv
// tremolo_modulator: LFO-driven amplitude modulation of signed audio samples
// ports: i_clk, i_rst_n (async low), i_en (0 = bypass), i_depth (0 shallow .. 3 full),
// i_lfo (signed triangle LFO), i_valid/i_sample in, o_ready (idle), o_valid pulse, o_sample out
module tremolo_modulator
    import effect_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int GAIN_W = 16,
    parameter int LFO_W  = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic [1:0]               i_depth,
    input  logic signed [LFO_W-1:0]  i_lfo,
    input  logic                     i_valid,
    input  logic signed [DATA_W-1:0] i_sample,
    output logic                     o_ready,
    output logic                     o_valid,
    output logic signed [DATA_W-1:0] o_sample
);
    state_t state;
    logic signed [DATA_W-1:0] sample_q;
    logic signed [LFO_W-1:0] lfo_q;
    logic [1:0] depth_q;
    logic en_q;
    logic signed [17:0] raw;
    logic [GAIN_W-1:0] clamped, gain;
    logic mul_done;
    logic signed [2*DATA_W-1:0] product;
    // 18 bits hold the full shifted LFO range, so out-of-range inputs clamp instead of wrapping
    assign raw = 18'(lfo_q >>> LFO_SHIFT) + 18'(GAIN_HALF);
    assign clamped = raw[17] ? '0 : raw[16] ? '1 : raw[15:0];
    // depth scales the distance below unity gain; depth 3 keeps the full swing
    assign gain = !en_q ? GAIN_W'(GAIN_ONE)
                        : GAIN_W'(GAIN_ONE) - ((GAIN_W'(GAIN_ONE) - clamped) >> (2'd3 - depth_q));
    assign o_ready = state == S_IDLE;
    seq_mul_su16 u_mul (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .start   (state == S_GAIN),
        .a       (sample_q),
        .b       (gain),
        .done    (mul_done),
        .product (product)
    );
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            sample_q <= '0;
            lfo_q    <= '0;
            depth_q  <= '0;
            en_q     <= 1'b0;
            o_valid  <= 1'b0;
            o_sample <= '0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                S_IDLE: if (i_valid) begin
                    sample_q <= i_sample;
                    lfo_q    <= i_lfo;
                    depth_q  <= i_depth;
                    en_q     <= i_en;
                    state    <= S_GAIN;
                end
                S_GAIN: state <= S_MUL;
                S_MUL: if (mul_done) begin
                    state    <= S_DONE;
                    o_valid  <= 1'b1;
                    // unity gain of 65535 would floor positive samples down by one, so bypass passes through
                    o_sample <= en_q ? DATA_W'(product >>> GAIN_W) : sample_q;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tremolo_modulator.sv
// tb_tremolo_modulator: directed self-checking bench for tremolo_modulator
module tb_tremolo_modulator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic [1:0] depth = '0;
    logic signed [31:0] lfo = '0;
    logic valid = 1'b0;
    logic signed [15:0] sample = '0;
    logic ready, out_valid;
    logic signed [15:0] out_sample;
    int checks = 0;
    int passed = 0;

    tremolo_modulator dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_en     (en),
        .i_depth  (depth),
        .i_lfo    (lfo),
        .i_valid  (valid),
        .i_sample (sample),
        .o_ready  (ready),
        .o_valid  (out_valid),
        .o_sample (out_sample)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic run(input string tag, input logic e, input logic [1:0] d,
                       input logic [31:0] l, input int s, input int exp);
        int n = 0;
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rdy"}, int'(ready), 1);
        en = e;
        depth = d;
        lfo = l;
        sample = 16'(s);
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        sample = 16'sd77;
        lfo = '0;
        depth = 2'd0;
        en = ~e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 40);
        check({tag, "_lat"}, n, 18);
        check({tag, "_val"}, int'(out_sample), exp);
        @(negedge clk);
        check({tag, "_pulse"}, int'(out_valid), 0);
        check({tag, "_hold"}, int'(out_sample), exp);
    endtask

    initial begin
        int q[$];
        int acc_cnt, pulses, last, dbl, nv;
        logic pv;
        #2;
        check("rst_ready", int'(ready), 1);
        check("rst_valid", int'(out_valid), 0);
        check("rst_sample", int'(out_sample), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run("mid",      1'b1, 2'd3, 32'h0000_0000,   1000,    500);
        run("pclamp",   1'b1, 2'd3, 32'h4000_0000,   1000,    999);
        run("pclamp_n", 1'b1, 2'd3, 32'h4000_0000, -32768, -32768);
        run("neg_d0",   1'b1, 2'd0, 32'hC000_0000,  -1000,   -875);
        run("neg_d3",   1'b1, 2'd3, 32'hC000_0000,  -1000,      0);
        run("d1",       1'b1, 2'd1, 32'h0000_0000,   1000,    875);
        run("d2",       1'b1, 2'd2, 32'h0000_0000,  -1000,   -750);
        run("floor",    1'b1, 2'd3, 32'h0000_0000,  -1001,   -501);
        run("maxlfo",   1'b1, 2'd3, 32'h7FFF_FFFF,   1000,    999);
        run("minlfo",   1'b1, 2'd3, 32'h8000_0000,   1000,      0);
        run("bypass",   1'b0, 2'd2, 32'h1234_5678, -12345, -12345);
        run("bypass_p", 1'b0, 2'd0, 32'hFFFF_FFFF,  12345,  12345);

        acc_cnt = 0;
        pulses = 0;
        last = -1;
        dbl = 0;
        pv = 1'b0;
        en = 1'b1;
        depth = 2'd3;
        lfo = '0;
        valid = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (out_valid) begin
                pulses++;
                if (q.size() > 0) check("busy_val", int'(out_sample), q.pop_front());
                if (last >= 0) check("busy_gap", c - last, 19);
                last = c;
            end
            if (pv && out_valid) dbl++;
            pv = out_valid;
            sample = 16'(100 + c * 10);
            if (ready) begin
                acc_cnt++;
                q.push_back((100 + c * 10) / 2);
            end
            @(negedge clk);
        end
        valid = 1'b0;
        check("busy_accepts", acc_cnt, 4);
        check("busy_pulses", pulses, 3);
        check("busy_single", dbl, 0);
        repeat (25) @(negedge clk);

        check("pre_rst_ready", int'(ready), 1);
        sample = 16'sd3000;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        check("mid_busy", int'(ready), 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_sample", int'(out_sample), 0);
        check("mid_rst_ready", int'(ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        check("mid_rst_novalid", nv, 0);
        run("after_rst", 1'b1, 2'd3, 32'h0000_0000, 200, 100);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end
endmodule
